// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: valid/ready word port of the PS/2 receiver with its fill level
interface ps2_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic [DATA_BITS+1:0]        out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  modport master (output out_data, out_valid, fifo_count, input out_ready);
  modport slave (input out_data, out_valid, fifo_count, output out_ready);
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: oversampled PS/2 frame receiver with prefix folding and a show-ahead output FIFO
module ps2_rx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 16,
  parameter int DECODE      = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_rx_fifo_if.master  out,
  output logic           parity_err,
  output logic           frame_err,
  output logic           overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  localparam logic [DATA_BITS-1:0] EXT_CODE = DATA_BITS'(8'hE0);
  localparam logic [DATA_BITS-1:0] BRK_CODE = DATA_BITS'(8'hF0);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [1:0] cs, ds;
  logic [7:0] fcnt;
  logic fclk, fall;
  logic [BW-1:0] bitcnt;
  logic [DATA_BITS-1:0] shreg;
  logic par, tout, done, done_n, perr_n, ferr_n;
  logic [TW-1:0] tcnt;
  logic ext, brk, is_pfx, push, pop, full, wr;
  logic [DATA_BITS+1:0] mem [FIFO_DEPTH];
  logic [DATA_BITS+1:0] last;
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  // fall is registered so it lines up with fclk having just dropped
  always_ff @(posedge clk)
    if (rst) begin
      cs <= 2'b11;
      ds <= 2'b11;
      fclk <= 1'b1;
      fcnt <= '0;
      fall <= 1'b0;
    end else begin
      cs <= {cs[0], ps2_clk};
      ds <= {ds[0], ps2_data};
      fall <= 1'b0;
      if (cs[1] == fclk) fcnt <= '0;
      else if (fcnt == 8'(FILTER_LEN - 1)) begin
        fcnt <= '0;
        fclk <= ~fclk;
        fall <= fclk;
      end else fcnt <= fcnt + 1'b1;
    end
  always_comb begin
    state_n = state;
    perr_n = 1'b0;
    ferr_n = 1'b0;
    done_n = 1'b0;
    tout = state != IDLE && tcnt == TW'(TIMEOUT_CYC);
    if (tout) begin
      state_n = IDLE;
      ferr_n = 1'b1;
    end else if (fall)
      case (state)
        IDLE:    state_n = ds[1] ? IDLE : DATA;
        DATA:    state_n = bitcnt == BW'(DATA_BITS - 1) ? PARITY : DATA;
        PARITY:  state_n = STOP;
        default: begin
          state_n = IDLE;
          perr_n = ~^{shreg, par};
          ferr_n = ^{shreg, par} & ~ds[1];
          done_n = ^{shreg, par} & ds[1];
        end
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      bitcnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      tcnt <= '0;
      done <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      done <= done_n;
      parity_err <= perr_n;
      frame_err <= ferr_n;
      tcnt <= (fall || state == IDLE) ? '0 : tcnt + 1'b1;
      if (fall && state == IDLE) bitcnt <= '0;
      if (fall && state == DATA && !tout) begin
        shreg <= {ds[1], shreg[DATA_BITS-1:1]};
        bitcnt <= bitcnt + 1'b1;
      end
      if (fall && state == PARITY && !tout) par <= ds[1];
    end
  // shreg stays stable after STOP, so the decoder reads it one cycle later
  always_comb begin
    is_pfx = DECODE != 0 && (shreg == EXT_CODE || shreg == BRK_CODE);
    push = done && !is_pfx;
    pop = out.out_valid && out.out_ready;
    full = count == (AW + 1)'(FIFO_DEPTH);
    wr = push && (!full || pop);
    overflow = push && full && !pop;
  end
  assign out.out_valid = count != '0;
  assign out.fifo_count = count;
  assign out.out_data = out.out_valid ? mem[rp] : last;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= {ext, brk, shreg};
  always_ff @(posedge clk)
    if (rst) begin
      ext <= 1'b0;
      brk <= 1'b0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      last <= '0;
    end else begin
      if (parity_err || frame_err) {ext, brk} <= 2'b00;
      else if (done && DECODE != 0)
        {ext, brk} <= shreg == EXT_CODE ? {1'b1, brk} : shreg == BRK_CODE ? {ext, 1'b1} : 2'b00;
      if (wr) wp <= wp + 1'b1;
      if (pop) begin
        rp <= rp + 1'b1;
        last <= mem[rp];
      end
      count <= count + (AW + 1)'(wr) - (AW + 1)'(pop);
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed and random PS/2 frames checked against a queue-based reference model
module tb_ps2_rx_fifo;
  localparam int F = 8, TO = 1000, DEPTH = 4, HALF = 24;
  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, rdy = 1'b0;
  logic parity_err, frame_err, overflow;
  int n_cmp = 0, n_err = 0, n_pop = 0;
  int obs_perr = 0, obs_ferr = 0, obs_ovf = 0, exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
  logic [9:0] exp_q[$];
  logic m_ext = 1'b0, m_brk = 1'b0;

  ps2_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) bus ();
  assign bus.out_ready = rdy;

  ps2_rx_fifo #(.DATA_BITS(8), .FILTER_LEN(F), .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH), .DECODE(1)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .out(bus),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst) begin
      obs_perr += int'(parity_err);
      obs_ferr += int'(frame_err);
      obs_ovf += int'(overflow);
      if (bus.out_valid && rdy) begin
        n_pop++;
        chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("word", 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
    end

  // reference: a frame either fails, sets a prefix flag, or becomes one queued word
  task automatic model(input logic [7:0] b, input bit bad_par, input logic stop, input bit coinc);
    if (bad_par || !stop) begin
      if (bad_par) exp_perr++;
      else exp_ferr++;
      {m_ext, m_brk} = 2'b00;
    end else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (exp_q.size() >= DEPTH && !rdy && !coinc) exp_ovf++;
      else exp_q.push_back({m_ext, m_brk, b});
      {m_ext, m_brk} = 2'b00;
    end
  endtask

  task automatic phase(input logic lvl, input int mode, input bit glitch);
    ps2_clk = lvl;
    for (int k = 1; k <= HALF; k++) begin
      @(posedge clk);
      #1;
      if (glitch && (k == 16 || k == 17)) ps2_clk = ~ps2_clk;
      if (mode == 2) rdy = (k == F + 3) ? 1'b1 : (k == F + 4) ? 1'b0 : rdy;
      if (mode == 1 && (k == F + 3 || k == F + 4)) begin
        @(negedge clk);
        chk(k == F + 3 ? "valid_before" : "valid_latency", 32'(bus.out_valid), 32'(k == F + 4));
      end
    end
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par = 1'b0, input logic stop = 1'b1,
                       input int mode = 0, input bit glitch = 1'b0);
    logic [10:0] bits;
    bits = {stop, ~^b ^ bad_par, b, 1'b0};
    model(b, bad_par, stop, mode == 2);
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      phase(1'b1, 0, glitch);
      phase(1'b0, i == 10 ? mode : 0, glitch);
    end
    ps2_data = 1'b1;
    phase(1'b1, 0, 1'b0);
  endtask

  task automatic partial(input int n, input bit do_rst);
    ps2_data = 1'b0;
    phase(1'b1, 0, 1'b0);
    phase(1'b0, 0, 1'b0);
    for (int i = 0; i < n; i++) begin
      ps2_data = 1'($urandom);
      phase(1'b1, 0, 1'b0);
      phase(1'b0, 0, 1'b0);
    end
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    {m_ext, m_brk} = 2'b00;
    if (do_rst) begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
    end else begin
      exp_ferr++;
      repeat (TO + 100) @(posedge clk);
      #1;
    end
    phase(1'b1, 0, 1'b0);
  endtask

  function automatic logic [7:0] rand_code();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (b == 8'hE0 || b == 8'hF0);
    return b;
  endfunction

  task automatic check_counts(input string tag);
    chk({tag, "_perr"}, obs_perr, exp_perr);
    chk({tag, "_ferr"}, obs_ferr, exp_ferr);
    chk({tag, "_ovf"}, obs_ovf, exp_ovf);
  endtask

  initial begin
    int pops;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_count", 32'(bus.fifo_count), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_pulses", 32'({parity_err, frame_err, overflow}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    phase(1'b1, 0, 1'b0);

    frame(8'h1C, 1'b0, 1'b1, 1);
    chk("count_one", 32'(bus.fifo_count), 1);
    chk("head_1c", 32'(bus.out_data), 32'h01C);
    rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_one", 32'(bus.out_valid), 0);

    pops = n_pop;
    frame(8'hF0); frame(8'h1C); frame(8'hE0); frame(8'hF0); frame(8'h75);
    chk("prefix_words", n_pop - pops, 2);
    check_counts("prefix");

    pops = n_pop;
    frame(8'h1C, 1'b1);
    chk("perr_once", obs_perr, 1);
    frame(8'hE0); frame(8'h12, 1'b0, 1'b0); frame(8'h6B);
    chk("ferr_once", obs_ferr, 1);
    chk("err_words", n_pop - pops, 1);
    check_counts("errors");

    pops = n_pop;
    frame(8'hE0);
    partial(4, 1'b0);
    chk("timeout_ferr", obs_ferr, 2);
    frame(8'h29);
    chk("timeout_words", n_pop - pops, 1);

    rdy = 1'b0;
    for (int i = 0; i <= DEPTH; i++) frame(rand_code());
    chk("full_count", 32'(bus.fifo_count), DEPTH);
    chk("ovf_once", obs_ovf, 1);
    rdy = 1'b1;
    repeat (DEPTH + 2) @(posedge clk);
    #1;
    chk("full_drained", exp_q.size(), 0);
    rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) frame(rand_code());
    frame(rand_code(), 1'b0, 1'b1, 2);
    chk("coinc_count", 32'(bus.fifo_count), DEPTH);
    chk("coinc_no_ovf", obs_ovf, 1);
    rdy = 1'b1;
    repeat (DEPTH + 2) @(posedge clk);
    #1;

    pops = n_pop;
    frame(8'h5A, 1'b0, 1'b1, 0, 1'b1);
    chk("glitch_words", n_pop - pops, 1);
    check_counts("glitch");

    pops = n_pop;
    frame(8'hE0);
    partial(3, 1'b1);
    chk("rst_mid_words", n_pop - pops, 0);
    frame(8'h6B);
    chk("rst_mid_after", n_pop - pops, 1);
    check_counts("rst_mid");

    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 8'hE0 : 8'hF0) : 8'($urandom);
      rdy = $urandom_range(0, 2) != 0;
      frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0);
    end
    rdy = 1'b1;
    repeat (DEPTH + 4) @(posedge clk);
    #1;
    chk("final_empty", exp_q.size(), 0);
    chk("final_valid", 32'(bus.out_valid), 0);
    check_counts("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no end of stimulus, required finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
